// File: rtl/mf8_alu.sv
// mf8 execute stage: combinational 8-bit ALU with registered {H,S,V,N,Z,C} flags,
// plus an 8-cycle shift-add unsigned multiply that writes its product back to R0/R1.
module mf8_alu (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic [3:0] op_i,
   input  logic [7:0] rd_data_i,
   input  logic [7:0] rr_data_i,
   input  logic [7:0] imm_i,
   input  logic       use_imm_i,
   input  logic       wb_en_i,
   output logic [7:0] data_out_o,
   output logic       wr_o,
   output logic       busy_o,
   output logic [1:0] addr_req_o,
   output logic [5:0] flags_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_WLO, S_WHI} state_t;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_EOR = 4'd6,  OP_MOV = 4'd7;
   localparam logic [3:0] OP_COM = 4'd8,  OP_NEG = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
   localparam logic [3:0] OP_LSR = 4'd12, OP_ROR = 4'd13, OP_ASR = 4'd14, OP_MUL = 4'd15;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [15:0] acc_q;
   logic [15:0] acc_d;
   logic [7:0]  mcand_q;
   logic [7:0]  mplier_q;
   logic [5:0]  flags_q;
   logic [5:0]  flags_d;

   logic [7:0]  a;
   logic [7:0]  b;
   logic        cin;
   logic        add_c;
   logic        sub_c;
   logic [7:0]  sub_a;
   logic [7:0]  sub_b;
   logic [8:0]  sum9;
   logic [4:0]  hsum;
   logic [8:0]  diff9;
   logic [4:0]  hdiff;
   logic [7:0]  res;
   logic        h, v, n, z, c;
   logic        accept;

   assign a      = rd_data_i;
   assign b      = use_imm_i ? imm_i : rr_data_i;
   assign cin    = flags_q[0];
   assign accept = start_i && (state_q == S_IDLE);

   // NEG shares the subtractor as 0 - A
   assign add_c = (op_i == OP_ADC) ? cin : 1'b0;
   assign sub_c = (op_i == OP_SBC) ? cin : 1'b0;
   assign sub_a = (op_i == OP_NEG) ? 8'h00 : a;
   assign sub_b = (op_i == OP_NEG) ? a : b;
   assign sum9  = {1'b0, a} + {1'b0, b} + {8'h00, add_c};
   assign hsum  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'h0, add_c};
   assign diff9 = {1'b0, sub_a} - {1'b0, sub_b} - {8'h00, sub_c};
   assign hdiff = {1'b0, sub_a[3:0]} - {1'b0, sub_b[3:0]} - {4'h0, sub_c};

   always_comb begin
      res = 8'h00;
      h   = flags_q[5];
      v   = flags_q[3];
      c   = flags_q[0];
      case (op_i)
         OP_ADD, OP_ADC: begin
            res = sum9[7:0];
            h   = hsum[4];
            c   = sum9[8];
            v   = (a[7] & b[7] & ~res[7]) | (~a[7] & ~b[7] & res[7]);
         end
         OP_SUB, OP_SBC: begin
            res = diff9[7:0];
            h   = hdiff[4];
            c   = diff9[8];
            v   = (a[7] & ~b[7] & ~res[7]) | (~a[7] & b[7] & res[7]);
         end
         OP_NEG: begin
            res = diff9[7:0];
            h   = hdiff[4];
            c   = (res != 8'h00);
            v   = (res == 8'h80);
         end
         OP_AND: begin res = a & b; v = 1'b0; end
         OP_OR:  begin res = a | b; v = 1'b0; end
         OP_EOR: begin res = a ^ b; v = 1'b0; end
         OP_MOV: res = b;
         OP_COM: begin res = ~a; c = 1'b1; v = 1'b0; end
         OP_INC: begin res = a + 8'd1; v = (res == 8'h80); end
         OP_DEC: begin res = a - 8'd1; v = (res == 8'h7F); end
         OP_LSR: begin res = {1'b0, a[7:1]};      c = a[0]; v = res[7] ^ a[0]; end
         OP_ROR: begin res = {flags_q[0], a[7:1]}; c = a[0]; v = res[7] ^ a[0]; end
         OP_ASR: begin res = {a[7], a[7:1]};      c = a[0]; v = res[7] ^ a[0]; end
         default: res = 8'h00;
      endcase
      n = res[7];
      z = (op_i == OP_SBC) ? (flags_q[1] & (res == 8'h00)) : (res == 8'h00);
      flags_d = {h, n ^ v, v, n, z, c};
   end

   assign acc_d = acc_q + (mplier_q[cnt_q[2:0]] ? ({8'h00, mcand_q} << cnt_q[2:0]) : 16'h0000);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         acc_q    <= 16'h0000;
         mcand_q  <= 8'h00;
         mplier_q <= 8'h00;
         flags_q  <= 6'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept && op_i == OP_MUL) begin
                  state_q  <= S_MUL;
                  cnt_q    <= 4'd0;
                  acc_q    <= 16'h0000;
                  mcand_q  <= a;
                  mplier_q <= b;
               end else if (accept && op_i != OP_MOV) begin
                  flags_q <= flags_d;
               end
            end
            S_MUL: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 4'd1;
               if (cnt_q == 4'd7) state_q <= S_WLO;
            end
            S_WLO: state_q <= S_WHI;
            S_WHI: begin
               flags_q <= {flags_q[5:2], (acc_q == 16'h0000), acc_q[15]};
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      wr_o       = 1'b0;
      data_out_o = res;
      addr_req_o = 2'b00;
      case (state_q)
         S_IDLE: wr_o = accept && wb_en_i && (op_i != OP_MUL);
         S_MUL:  if (cnt_q == 4'd7) addr_req_o = 2'b01;
         S_WLO: begin
            wr_o       = 1'b1;
            data_out_o = acc_q[7:0];
            addr_req_o = 2'b10;
         end
         S_WHI: begin
            wr_o       = 1'b1;
            data_out_o = acc_q[15:8];
         end
         default: wr_o = 1'b0;
      endcase
      if (reset_i) wr_o = 1'b0;
   end

   assign busy_o  = (state_q != S_IDLE);
   assign flags_o = flags_q;

endmodule

// File: tb/tb_mf8_alu.sv
// Directed testbench for mf8_alu: single-cycle ops, flag rules, multiply sequencing and abort.
module tb_mf8_alu;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] op;
   logic [7:0] rd_data;
   logic [7:0] rr_data;
   logic [7:0] imm;
   logic       use_imm;
   logic       wb_en;
   logic [7:0] data_out;
   logic       wr;
   logic       busy;
   logic [1:0] addr_req;
   logic [5:0] flags;

   int n_checks = 0;
   int n_fail   = 0;

   mf8_alu dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .start_i    (start),
      .op_i       (op),
      .rd_data_i  (rd_data),
      .rr_data_i  (rr_data),
      .imm_i      (imm),
      .use_imm_i  (use_imm),
      .wb_en_i    (wb_en),
      .data_out_o (data_out),
      .wr_o       (wr),
      .busy_o     (busy),
      .addr_req_o (addr_req),
      .flags_o    (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs at the falling edge, then settles before any check.
   task automatic drive(input logic s, input logic [3:0] o, input logic [7:0] a, input logic [7:0] rb,
                        input logic ui, input logic [7:0] im, input logic we);
      @(negedge clk);
      start = s; op = o; rd_data = a; rr_data = rb; use_imm = ui; imm = im; wb_en = we;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if ({busy, wr, addr_req, flags} !== {1'b0, 1'b0, 2'b00, 6'h00}) begin
         n_fail++;
         $display("FAIL reset_state: busy/wr/addr/flags=%b/%b/%b/%b want 0/0/00/000000", busy, wr, addr_req, flags);
      end
   endtask

   task automatic test_add();
      drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({wr, data_out} !== {1'b1, 8'h80}) begin
         n_fail++;
         $display("FAIL add_wb: wr=%b data=%h want 1 80", wr, data_out);
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (flags !== 6'b101100) begin
         n_fail++;
         $display("FAIL add_flags: flags=%b want 101100", flags);
      end
   endtask

   task automatic test_sub_sbc();
      logic [7:0] sa [4] = '{8'h05, 8'h05, 8'h00, 8'h00};
      logic [7:0] sb [4] = '{8'h05, 8'h04, 8'h01, 8'h00};
      logic [7:0] r1 [4] = '{8'h00, 8'h01, 8'hFF, 8'h00};
      logic [5:0] f1 [4] = '{6'b000010, 6'b000000, 6'b110101, 6'b000000};
      logic [5:0] f2 [4] = '{6'b000010, 6'b000000, 6'b110101, 6'b000000};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd2, sa[i], sb[i], 1'b0, 8'h00, 1'b1);
         n_checks++;
         if ({wr, data_out} !== {1'b1, r1[i]}) begin
            n_fail++;
            $display("FAIL sub_%0d: wr=%b data=%h want 1 %h", i, wr, data_out, r1[i]);
         end
         drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
         n_checks++;
         if (flags !== f1[i]) begin
            n_fail++;
            $display("FAIL sub_flags_%0d: flags=%b want %b", i, flags, f1[i]);
         end
         if (i < 2) begin
            drive(1'b1, 4'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
            drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
            n_checks++;
            if (flags !== f2[i]) begin
               n_fail++;
               $display("FAIL sbc_z_%0d: flags=%b want %b", i, flags, f2[i]);
            end
         end
      end
      // C=1 from 0x00-0x01 feeds ADC: 0x10+0x20+1
      drive(1'b1, 4'd1, 8'h10, 8'h20, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if (data_out !== 8'h31) begin
         n_fail++;
         $display("FAIL adc_carry: data=%h want 31", data_out);
      end
   endtask

   task automatic test_cp_mov();
      drive(1'b1, 4'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (wr !== 1'b0) begin
         n_fail++;
         $display("FAIL cp_add_wr: wr=%b want 0", wr);
      end
      drive(1'b1, 4'd2, 8'h80, 8'hAA, 1'b1, 8'h01, 1'b0);
      n_checks++;
      if ({wr, flags} !== {1'b0, 6'b100011}) begin
         n_fail++;
         $display("FAIL cp_sub: wr=%b flags=%b want 0 100011", wr, flags);
      end
      drive(1'b1, 4'd7, 8'h12, 8'h34, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({wr, data_out, flags} !== {1'b1, 8'h34, 6'b111000}) begin
         n_fail++;
         $display("FAIL mov: wr=%b data=%h flags=%b want 1 34 111000", wr, data_out, flags);
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (flags !== 6'b111000) begin
         n_fail++;
         $display("FAIL mov_flags: flags=%b want 111000", flags);
      end
   endtask

   task automatic test_shift_neg();
      logic [3:0] ops [4] = '{4'd12, 4'd13, 4'd14, 4'd9};
      logic [7:0] av  [4] = '{8'h01, 8'h02, 8'h80, 8'h01};
      logic [7:0] rv  [4] = '{8'h00, 8'h81, 8'hC0, 8'hFF};
      logic [5:0] fv  [4] = '{6'b111011, 6'b101100, 6'b101100, 6'b110101};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ops[i], av[i], 8'h00, 1'b0, 8'h00, 1'b1);
         n_checks++;
         if (data_out !== rv[i]) begin
            n_fail++;
            $display("FAIL unary_res_%0d: data=%h want %h", i, data_out, rv[i]);
         end
         drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
         n_checks++;
         if (flags !== fv[i]) begin
            n_fail++;
            $display("FAIL unary_flags_%0d: flags=%b want %b", i, flags, fv[i]);
         end
      end
   endtask

   // Runs T0..T11 of a multiply; optional ADD pulse at T4 must be ignored.
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                          input logic [5:0] fexp, input logic inject);
      logic       ebusy, ewr;
      logic [1:0] eaddr;
      logic [7:0] edata;
      for (int t = 0; t <= 11; t++) begin
         if (t == 0)                drive(1'b1, 4'd15, a, b, 1'b0, 8'h00, 1'b0);
         else if (inject && t == 4) drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
         else                       drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
         ebusy = (t >= 1 && t <= 10);
         ewr   = (t == 9 || t == 10);
         eaddr = (t == 8) ? 2'b01 : (t == 9) ? 2'b10 : 2'b00;
         edata = (t == 9) ? p[7:0] : p[15:8];
         n_checks++;
         if ({busy, wr, addr_req} !== {ebusy, ewr, eaddr} || (ewr && data_out !== edata)) begin
            n_fail++;
            $display("FAIL mul_T%0d: busy=%b wr=%b addr=%b data=%h want %b %b %b %h",
                     t, busy, wr, addr_req, data_out, ebusy, ewr, eaddr, edata);
         end
      end
      n_checks++;
      if (flags !== fexp) begin
         n_fail++;
         $display("FAIL mul_flags: flags=%b want %b", flags, fexp);
      end
   endtask

   task automatic test_mul();
      do_reset();
      run_mul(8'hFF, 8'hFF, 16'hFE01, 6'b000001, 1'b0);
      run_mul(8'h00, 8'h37, 16'h0000, 6'b000010, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_reset();
      run_mul(8'h03, 8'h05, 16'h000F, 6'b000000, 1'b1);
      drive(1'b1, 4'd0, 8'h01, 8'h02, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({wr, data_out} !== {1'b1, 8'h03}) begin
         n_fail++;
         $display("FAIL post_mul_add: wr=%b data=%h want 1 03", wr, data_out);
      end
   endtask

   task automatic test_mul_reset();
      drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
      for (int t = 0; t <= 12; t++) begin
         reset = (t == 5);
         if (t == 0) drive(1'b1, 4'd15, 8'h02, 8'h03, 1'b0, 8'h00, 1'b0);
         else        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
         if (t >= 6) begin
            n_checks++;
            if ({busy, wr, addr_req, flags} !== {1'b0, 1'b0, 2'b00, 6'h00}) begin
               n_fail++;
               $display("FAIL mul_abort_T%0d: busy=%b wr=%b addr=%b flags=%b want 0 0 00 000000",
                        t, busy, wr, addr_req, flags);
            end
         end
      end
      reset = 1'b0;
      drive(1'b1, 4'd0, 8'h7F, 8'h01, 1'b0, 8'h00, 1'b1);
      n_checks++;
      if ({wr, data_out} !== {1'b1, 8'h80}) begin
         n_fail++;
         $display("FAIL abort_next_add: wr=%b data=%h want 1 80", wr, data_out);
      end
      drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      n_checks++;
      if (flags !== 6'b101100) begin
         n_fail++;
         $display("FAIL abort_next_flags: flags=%b want 101100", flags);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 4'd0; rd_data = 8'h00; rr_data = 8'h00;
      imm = 8'h00; use_imm = 1'b0; wb_en = 1'b0;
      test_reset();
      test_add();
      test_sub_sbc();
      test_cp_mov();
      test_shift_neg();
      test_mul();
      test_back_to_back();
      test_mul_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
